// File: rtl/uart_duplex_core.sv
// uart_duplex_core: full-duplex UART with runtime frame format, baud divisor
// and show-ahead byte FIFOs on both the transmit and receive side.

// Circular-buffer FIFO with an extra pointer bit to tell full from empty.
module uart_duplex_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wptr, rptr;
   logic         do_wr, do_rd;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_rd   = rd_en && !empty;
   // a simultaneous pop frees the slot, so a write on full still lands
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rptr[AW-1:0]];

   // storage and pointer update; storage is cleared so the head reads 0 after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_wr) begin
            mem[wptr[AW-1:0]] <= wr_data;
            wptr              <= wptr + PTR_ONE;
         end
         if (do_rd) rptr <= rptr + PTR_ONE;
      end
   end
endmodule

module uart_duplex_core #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DIV_WIDTH-1:0] baud_div,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 two_stop,
   input  logic                 rxd,
   output logic                 txd,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun
);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   typedef struct packed {
      logic                 frame_err;
      logic                 parity_err;
      logic [DATA_BITS-1:0] data;
   } rx_ent_t;

   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   // divisors below 4 leave no room for a mid-bit sample
   logic [DIV_WIDTH-1:0] div_eff;
   assign div_eff = (baud_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : baud_div;

   // ---------------------------------------------------------------- TX side
   state_t               tx_st;
   logic [DIV_WIDTH-1:0] tx_div, tx_cnt;
   logic [3:0]           tx_idx;
   logic [DATA_BITS-1:0] tx_sh, tx_head;
   logic                 tx_par_en, tx_two, tx_par;
   logic                 tx_full, tx_empty, tx_pop, tx_bit_end, tx_last_stop;
   logic                 tx_line, busy_now, busy_q;

   assign tx_ready = !tx_full;

   uart_duplex_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (tx_valid && tx_ready),
      .wr_data (tx_data),
      .rd_en   (tx_pop),
      .rd_data (tx_head),
      .full    (tx_full),
      .empty   (tx_empty)
   );

   assign tx_bit_end   = (tx_cnt == tx_div - 1'b1);
   assign tx_last_stop = (tx_st == S_STOP) && tx_bit_end && (!tx_two || tx_idx[0]);
   // load a new frame from idle, or back-to-back straight out of the last stop bit
   assign tx_pop       = !tx_empty && ((tx_st == S_IDLE) || tx_last_stop);

   // txd is one register behind the state, so the line falls two edges after accept
   assign busy_now = (tx_st != S_IDLE) || !tx_empty;
   assign tx_busy  = busy_now || busy_q;

   // line level for the bit currently being timed
   always_comb begin
      tx_line = 1'b1;
      unique case (tx_st)
         S_START: tx_line = 1'b0;
         S_DATA:  tx_line = tx_sh[0];
         S_PAR:   tx_line = tx_par;
         default: tx_line = 1'b1;
      endcase
   end

   // TX frame sequencer; format and divisor latched when a frame is loaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_st     <= S_IDLE;
         tx_cnt    <= '0;
         tx_div    <= DIV_WIDTH'(4);
         tx_idx    <= '0;
         tx_sh     <= '0;
         tx_par_en <= 1'b0;
         tx_two    <= 1'b0;
         tx_par    <= 1'b0;
         txd       <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         txd    <= tx_line;
         busy_q <= busy_now;
         if (tx_pop) begin
            tx_st     <= S_START;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_sh     <= tx_head;
            tx_div    <= div_eff;
            tx_par_en <= parity_en;
            tx_two    <= two_stop;
            tx_par    <= (^tx_head) ^ parity_odd;
         end else if (tx_st != S_IDLE) begin
            if (!tx_bit_end) begin
               tx_cnt <= tx_cnt + 1'b1;
            end else begin
               tx_cnt <= '0;
               unique case (tx_st)
                  S_START: tx_st <= S_DATA;
                  S_DATA: begin
                     tx_sh <= tx_sh >> 1;
                     if (tx_idx == LAST_BIT) begin
                        tx_idx <= '0;
                        tx_st  <= tx_par_en ? S_PAR : S_STOP;
                     end else begin
                        tx_idx <= tx_idx + 1'b1;
                     end
                  end
                  S_PAR:   tx_st <= S_STOP;
                  S_STOP: begin
                     if (tx_last_stop) tx_st  <= S_IDLE;
                     else              tx_idx <= tx_idx + 1'b1;
                  end
                  default: tx_st <= S_IDLE;
               endcase
            end
         end
      end
   end

   // ---------------------------------------------------------------- RX side
   state_t               rx_st;
   logic                 rx_s1, rx_s2;
   logic [DIV_WIDTH-1:0] rx_div, rx_cnt;
   logic [3:0]           rx_idx;
   logic [DATA_BITS-1:0] rx_sh;
   logic                 rx_par_en, rx_odd, rx_perr;
   logic                 rx_full, rx_empty, rx_push, rx_bit_end;
   rx_ent_t              rx_wr, rx_head;

   // two-flop synchroniser, idles high so reset does not look like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= rxd;
         rx_s2 <= rx_s1;
      end
   end

   assign rx_bit_end = (rx_cnt == rx_div - 1'b1);
   // push straight off the stop mid-sample to keep receive latency short
   assign rx_push    = (rx_st == S_STOP) && rx_bit_end;
   assign rx_wr      = '{frame_err: !rx_s2, parity_err: rx_perr, data: rx_sh};

   uart_duplex_fifo #(.W(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (rx_push),
      .wr_data (rx_wr),
      .rd_en   (rx_ready),
      .rd_data (rx_head),
      .full    (rx_full),
      .empty   (rx_empty)
   );

   assign rx_valid      = !rx_empty;
   assign rx_data       = rx_head.data;
   assign rx_parity_err = rx_head.parity_err;
   assign rx_frame_err  = rx_head.frame_err;

   // RX frame sequencer; counter restarts at each sample so later bits land mid-bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_st      <= S_IDLE;
         rx_cnt     <= '0;
         rx_div     <= DIV_WIDTH'(4);
         rx_idx     <= '0;
         rx_sh      <= '0;
         rx_par_en  <= 1'b0;
         rx_odd     <= 1'b0;
         rx_perr    <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         // a full FIFO only drops the byte when nobody pops in the same cycle
         rx_overrun <= rx_push && rx_full && !rx_ready;
         unique case (rx_st)
            S_IDLE: begin
               if (!rx_s2) begin
                  rx_st     <= S_START;
                  rx_cnt    <= '0;
                  rx_idx    <= '0;
                  rx_perr   <= 1'b0;
                  rx_div    <= div_eff;
                  rx_par_en <= parity_en;
                  rx_odd    <= parity_odd;
               end
            end
            S_START: begin
               if (rx_cnt == (rx_div >> 1)) begin
                  rx_cnt <= '0;
                  rx_st  <= rx_s2 ? S_IDLE : S_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (rx_bit_end) begin
                  rx_cnt <= '0;
                  rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                  if (rx_idx == LAST_BIT) begin
                     rx_idx <= '0;
                     rx_st  <= rx_par_en ? S_PAR : S_STOP;
                  end else begin
                     rx_idx <= rx_idx + 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            S_PAR: begin
               if (rx_bit_end) begin
                  rx_cnt  <= '0;
                  rx_perr <= rx_s2 != ((^rx_sh) ^ rx_odd);
                  rx_st   <= S_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (rx_bit_end) begin
                  rx_cnt <= '0;
                  rx_st  <= S_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_st <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_duplex_core.sv
// Directed bench for uart_duplex_core: loopback, parity/framing errors,
// overrun, back-to-back 7O2 transmit, glitch rejection and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_duplex_core;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] baud_div = 16'd16;
   logic        parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0;
   logic        bfm_rxd = 1'b1, loop_en = 1'b0;
   logic        rxd, txd;
   logic [7:0]  tx_data = '0;
   logic        tx_valid = 1'b0, tx_ready, tx_busy;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_ready = 1'b0, rx_parity_err, rx_frame_err, rx_overrun;

   logic [6:0]  tx_data7 = '0;
   logic        tx_valid7 = 1'b0, txd7, tx_ready7, tx_busy7;
   logic [6:0]  rx_data7;
   logic        rx_valid7, rx_pe7, rx_fe7, rx_ov7;

   assign rxd = loop_en ? txd : bfm_rxd;

   uart_duplex_core #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_en(parity_en),
      .parity_odd(parity_odd), .two_stop(two_stop), .rxd(rxd), .txd(txd),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
   );

   // 7O2 transmitter at div=8
   uart_duplex_core #(.DATA_BITS(7), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut7 (
      .clk(clk), .rst_n(rst_n), .baud_div(16'd8), .parity_en(1'b1),
      .parity_odd(1'b1), .two_stop(1'b1), .rxd(1'b1), .txd(txd7),
      .tx_data(tx_data7), .tx_valid(tx_valid7), .tx_ready(tx_ready7), .tx_busy(tx_busy7),
      .rx_data(rx_data7), .rx_valid(rx_valid7), .rx_ready(1'b0),
      .rx_parity_err(rx_pe7), .rx_frame_err(rx_fe7), .rx_overrun(rx_ov7)
   );

   int checks = 0;
   int errors = 0;
   int ovr_cnt = 0;

   always @(negedge clk) if (rx_overrun) ovr_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // drive one frame on rxd; a low stop bit is followed by two idle bits
   task automatic send_rx(input logic [7:0] d, input logic pen, input logic podd,
                          input logic pflip, input logic stopv, input int div);
      bfm_rxd = 1'b0;
      repeat (div) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bfm_rxd = d[i];
         repeat (div) @(negedge clk);
      end
      if (pen) begin
         bfm_rxd = (^d) ^ podd ^ pflip;
         repeat (div) @(negedge clk);
      end
      bfm_rxd = stopv;
      repeat (div) @(negedge clk);
      bfm_rxd = 1'b1;
      if (!stopv) repeat (2 * div) @(negedge clk);
   endtask

   task automatic wait_rx(input string tag);
      int n = 0;
      while (!rx_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, rx_valid}, 32'd1);
   endtask

   task automatic pop_rx();
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   // wait for a start bit on the selected txd, then sample each bit mid-way
   task automatic capture_tx(input bit sel, input int div, input int nbits,
                             output logic [63:0] bits, output int lat);
      lat  = 0;
      bits = '0;
      do begin
         @(negedge clk);
         lat++;
      end while ((sel ? txd7 : txd) !== 1'b0 && lat < 5000);
      repeat (div / 2 - 1) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         bits[i] = sel ? txd7 : txd;
         if (i < nbits - 1) repeat (div) @(negedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] bits;
      int          lat, ovr0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      chk("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
      chk("rst_perr", {31'd0, rx_parity_err}, 32'd0);
      chk("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
      chk("rst_ovr", {31'd0, rx_overrun}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 8N1 loopback of 0xA5 at div 16
      loop_en  = 1'b1;
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      capture_tx(1'b0, 16, 10, bits, lat);
      chk("t1_latency", lat, 32'd2);
      chk("t1_bits", {22'd0, bits[9:0]}, 32'b1101001010);
      chk("t1_busy", {31'd0, tx_busy}, 32'd1);
      wait_rx("t1_rx_valid");
      chk("t1_rx_data", {24'd0, rx_data}, 32'hA5);
      chk("t1_perr", {31'd0, rx_parity_err}, 32'd0);
      chk("t1_ferr", {31'd0, rx_frame_err}, 32'd0);
      pop_rx();
      repeat (20) @(negedge clk);
      chk("t1_idle_busy", {31'd0, tx_busy}, 32'd0);
      loop_en = 1'b0;

      // 8E1 with bad then good parity
      parity_en = 1'b1;
      send_rx(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 16);
      wait_rx("t2_valid_bad");
      chk("t2_data_bad", {24'd0, rx_data}, 32'h3C);
      chk("t2_perr_bad", {31'd0, rx_parity_err}, 32'd1);
      pop_rx();
      send_rx(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 16);
      wait_rx("t2_valid_good");
      chk("t2_data_good", {24'd0, rx_data}, 32'h3C);
      chk("t2_perr_good", {31'd0, rx_parity_err}, 32'd0);
      pop_rx();

      // 8N1 frame error then clean recovery
      parity_en = 1'b0;
      send_rx(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 16);
      wait_rx("t3_valid_err");
      chk("t3_data_err", {24'd0, rx_data}, 32'h81);
      chk("t3_ferr_err", {31'd0, rx_frame_err}, 32'd1);
      pop_rx();
      send_rx(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 16);
      wait_rx("t3_valid_ok");
      chk("t3_data_ok", {24'd0, rx_data}, 32'h55);
      chk("t3_ferr_ok", {31'd0, rx_frame_err}, 32'd0);
      chk("t3_perr_ok", {31'd0, rx_parity_err}, 32'd0);
      pop_rx();
      chk("t3_no_extra", {31'd0, rx_valid}, 32'd0);

      // overrun with a 4-deep FIFO and no pops
      ovr0 = ovr_cnt;
      for (int i = 1; i <= 4; i++) send_rx(8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 16);
      chk("t4_ovr_before", ovr_cnt - ovr0, 32'd0);
      send_rx(8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 16);
      chk("t4_ovr_after", ovr_cnt - ovr0, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         chk("t4_drain_data", {24'd0, rx_data}, i);
         pop_rx();
      end
      chk("t4_drained", {31'd0, rx_valid}, 32'd0);

      // 7O2 back-to-back frames at div 8
      tx_valid7 = 1'b1;
      tx_data7  = 7'h12;
      @(negedge clk);
      tx_data7  = 7'h34;
      @(negedge clk);
      tx_data7  = 7'h56;
      @(negedge clk);
      tx_valid7 = 1'b0;
      capture_tx(1'b1, 8, 33, bits, lat);
      chk("t5_frame1", {21'd0, bits[10:0]}, 32'b11100100100);
      chk("t5_frame2", {21'd0, bits[21:11]}, 32'b11001101000);
      chk("t5_frame3", {21'd0, bits[32:22]}, 32'b11110101100);
      chk("t5_busy_stop", {31'd0, tx_busy7}, 32'd1);
      repeat (8) @(negedge clk);
      chk("t5_busy_done", {31'd0, tx_busy7}, 32'd0);
      chk("t5_txd_idle", {31'd0, txd7}, 32'd1);

      // short low glitch must not start a frame
      bfm_rxd = 1'b0;
      repeat (3) @(negedge clk);
      bfm_rxd = 1'b1;
      repeat (48) @(negedge clk);
      chk("t6_glitch", {31'd0, rx_valid}, 32'd0);

      // reset in the middle of a transmitted frame
      tx_data  = 8'hF0;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (40) @(negedge clk);
      chk("t6_midframe_low", {31'd0, txd}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_txd", {31'd0, txd}, 32'd1);
      chk("t6_rst_busy", {31'd0, tx_busy}, 32'd0);
      chk("t6_rst_ready", {31'd0, tx_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("t6_post_txd", {31'd0, txd}, 32'd1);
      chk("t6_post_busy", {31'd0, tx_busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_duplex_core.md
# uart_duplex_core

Full-duplex, runtime-configurable UART with independent RX and TX state machines and parametrised FIFOs on both directions. It succeeds the single-FSM receive-then-replay transceiver: RX and TX run concurrently, and frame format and baud divisor are set by ports rather than elaboration constants. Parity and framing errors are reported per byte, and overrun is flagged. It sits between the board UART pins (ESP32 / USB-UART) and the cartridge data path, with valid/ready byte streams on the fabric side.

## Interface
- DATA_BITS, 8: payload bits per frame, legal 5..8.
- FIFO_DEPTH, 16: entries per FIFO, power of two, ≥2.
- DIV_WIDTH, 16: width of baud_div.

- clk  in  1  system clock (125 MHz on Zybo Z7-10).
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- baud_div  in  DIV_WIDTH  clocks per bit; values <4 are treated as 4.
- parity_en  in  1  1 = parity bit after data.
- parity_odd  in  1  1 = odd parity, 0 = even.
- two_stop  in  1  TX sends 2 stop bits; RX checks only the first.
- rxd  in  1  serial in, asynchronous.
- txd  out  1  serial out, idle high.
- tx_data  in  DATA_BITS  byte to send.
- tx_valid  in  1  write request.
- tx_ready  out  1  TX FIFO not full.
- tx_busy  out  1  TX FSM not IDLE or TX FIFO not empty.
- rx_data  out  DATA_BITS  head of RX FIFO (show-ahead).
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  pop request.
- rx_parity_err  out  1  parity error flag of head entry.
- rx_frame_err  out  1  stop-bit error flag of head entry.
- rx_overrun  out  1  one-cycle pulse when a received byte is dropped.

## Operation
- rxd passes through a 2-flop synchroniser preset to 1; all RX decisions use the synchronised value.
- baud_div, parity_en, parity_odd and two_stop are latched per direction at frame start. Mid-frame changes affect only the next frame.
- RX FSM: IDLE → START on synchronised low. START samples at count = div/2: high → false start, back to IDLE with no flag; low → DATA. DATA samples each bit at mid-bit, LSB first, DATA_BITS bits. Then PARITY (if enabled) compares the received bit against XOR(data)^parity_odd. STOP samples at mid-bit: low sets frame_err.
- RX returns to IDLE right after the stop mid-sample, so it can resync within half a bit.
- On stop sample, {frame_err, parity_err, data} is pushed to the RX FIFO, including errored bytes.
- If the RX FIFO is full and no pop happens the same cycle, the byte is dropped and rx_overrun pulses. Push plus pop on a full FIFO: both succeed, no overrun.
- TX FSM: IDLE → START when the FIFO is non-empty. The head is popped into a shift register on that transition. START, DATA (LSB first), PARITY (if enabled) and STOP (1 or 2 bits) each last div clocks. After STOP, go straight to START if the FIFO is non-empty (no idle gap), else IDLE.
- FIFOs: circular buffers with log2(DEPTH)+1-bit pointers. Pointers wrap at DEPTH; full/empty come from the MSB compare. A write when full is ignored (tx_valid with tx_ready low). A pop when empty is ignored.

## Timing
- Reset (async assert, sync deassert via clk): txd=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, err flags=0, rx_overrun=0. Both FIFOs are emptied and both FSMs go to IDLE.
- Reset mid-frame aborts the frame; txd goes high immediately.
- TX accept: edge k with tx_valid & tx_ready. From IDLE, txd falls on edge k+2. Each bit lasts exactly div clocks. Frame length = div·(1+DATA_BITS+parity_en+1+two_stop).
- RX latency: rx_valid rises ≤3 clocks after the stop-bit mid-sample point at the pin (2 sync + 1 push).
- Mid-bit sample offset: div/2 (floor) counted from the synchronised falling edge.
- Tolerance: correct reception with ±3 % baud mismatch at div ≥16.
- rx_data and the error flags are registered FIFO outputs, stable while rx_valid & !rx_ready.

## Test plan
- div=16, 8N1, tx_data=0xA5 looped txd→rxd → rx_data=0xA5, both err flags 0. txd low-time pattern matches 0,1,0,1,0,0,1,0,1,1 at 16 clocks per bit.
- 8E1, BFM sends 0x3C with the parity bit inverted → rx_data=0x3C, rx_parity_err=1. Next correct frame 0x3C → flag 0.
- 8N1, BFM holds stop bit low for 0x81 → rx_frame_err=1. RX recovers and receives the following 0x55 cleanly.
- FIFO_DEPTH=4, rx_ready=0, 5 frames 0x01..0x05 → exactly one rx_overrun pulse, at frame 5. Draining yields 0x01..0x04.
- 7O2, div=8, three back-to-back writes 0x12,0x34,0x56 → contiguous frames with no idle gap, 2 stop bits each, odd parity correct. tx_busy drops after the last stop bit.
- rxd low glitch of 3 clocks at div=16 → no push. Then rst_n asserted mid-TX frame → txd=1 within the same cycle and tx_busy=0.
